// File: rtl/uart_rx_buf.sv
// 8N1 UART receiver with a one-byte holding buffer and valid/ready output handshake.
// Bit timing comes from a fixed integer divider of the single clock.
module uart_rx_buf #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF     = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          meta_q, rxs_q;
    logic          good_q, good_d;
    logic          bad_q, bad_d;
    logic          busy_q, busy_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q;
    logic          ovr_q, ovr_d;
    logic          xfer_c;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            rxs_q  <= 1'b1;
        end else begin
            meta_q <= uart_rxd;
            rxs_q  <= meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            good_q  <= 1'b0;
            bad_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            busy_q  <= busy_d;
        end
    end

    // Counter value N-1 marks the edge N cycles after the last clear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        good_d  = 1'b0;
        bad_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        good_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                cnt_d = '0;
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    assign xfer_c = valid_q & rx_ready;

    // A finished byte loads only into an empty or simultaneously drained buffer.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (good_q) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (xfer_c) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= bad_q;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = busy_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_buf.sv
// Bench for uart_rx_buf at 16 clocks per bit: frame table, hand-written corner
// sequences, and an event scoreboard fed at stimulus time.
module tb_uart_rx_buf;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       reset_n;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    uart_rx_buf #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .uart_rxd  (uart_rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {K_BYTE, K_FERR, K_OVR} kind_t;
    typedef struct {
        kind_t      kind;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    ev_t  sb_q[$];
    vec_t vecs[6];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic prev_valid = 1'b0;
    logic prev_xfer  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input kind_t k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input kind_t k, input logic [7:0] d, input string name);
        ev_t e;
        if (sb_q.size() == 0) begin
            check({name, "_unexpected"}, 32'(k), 32'hFFFF_FFFF);
        end else begin
            e = sb_q.pop_front();
            check({name, "_kind"}, 32'(k), 32'(e.kind));
            if (k == K_BYTE) check({name, "_data"}, 32'(d), 32'(e.data));
        end
    endtask

    // Output event monitor: loads, framing errors and overruns.
    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_err) sb_pop(K_FERR, 8'h00, "frame_err");
            if (overrun) sb_pop(K_OVR, 8'h00, "overrun");
            if (rx_valid && (!prev_valid || prev_xfer)) sb_pop(K_BYTE, rx_data, "rx_byte");
        end
        prev_valid = rx_valid;
        prev_xfer  = rx_valid && rx_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        uart_rxd = v;
        repeat (CPB) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (rx_busy && n < 300) begin
            tick();
            n++;
        end
        if (rx_busy) check("idle_timeout", 32'(rx_busy), 32'd0);
    endtask

    task automatic pulse_ready();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        @(negedge clk);
        check("ready_clears_valid", 32'(rx_valid), 32'd0);
        tick();
    endtask

    int   busy_rise, busy_fall, valid_rise;
    logic ferr_seen, busy_seen;

    initial begin
        vecs[0] = '{data: 8'h3C, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h3C};
        vecs[1] = '{data: 8'hC3, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h3C};
        vecs[2] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h81};
        vecs[3] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h00};
        vecs[4] = '{data: 8'hE7, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00};
        vecs[5] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hFF};

        reset_n  = 1'b0;
        uart_rxd = 1'b1;
        rx_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_busy", 32'(rx_busy), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        check("post_rst_busy", 32'(rx_busy), 32'd0);

        // Single byte with exact edge timing relative to the line falling.
        busy_rise = 0; busy_fall = 0; valid_rise = 0; ferr_seen = 1'b0;
        push(K_BYTE, 8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int c = 1; c <= 170; c++) begin
                    tick();
                    if (rx_busy && busy_rise == 0) busy_rise = c;
                    if (!rx_busy && busy_rise != 0 && busy_fall == 0) busy_fall = c;
                    if (rx_valid && valid_rise == 0) valid_rise = c;
                    if (frame_err) ferr_seen = 1'b1;
                end
            end
        join
        check("a5_busy_rise_edge", 32'(busy_rise), 32'd3);
        check("a5_busy_fall_edge", 32'(busy_fall), 32'd155);
        check("a5_valid_rise_edge", 32'(valid_rise), 32'd156);
        check("a5_no_frame_err", 32'(ferr_seen), 32'd0);
        @(negedge clk);
        check("a5_rx_data", 32'(rx_data), 32'hA5);
        tick();
        pulse_ready();

        // Short low glitch must not start a frame.
        busy_seen = 1'b0;
        uart_rxd = 1'b0;
        repeat (4) tick();
        uart_rxd = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (rx_busy) busy_seen = 1'b1;
        end
        check("glitch_busy_pulse", 32'(busy_seen), 32'd1);
        check("glitch_busy_end", 32'(rx_busy), 32'd0);
        check("glitch_no_valid", 32'(rx_valid), 32'd0);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].stop) push(K_BYTE, vecs[v].data);
            else push(K_FERR, 8'h00);
            send_frame(vecs[v].data, vecs[v].stop);
            if (!vecs[v].stop) begin
                uart_rxd = 1'b0;
                repeat (40) tick();
                check("ferr_busy_held", 32'(rx_busy), 32'd1);
                uart_rxd = 1'b1;
                repeat (4) tick();
            end
            wait_idle();
            repeat (2) tick();
            @(negedge clk);
            check("vec_rx_valid", 32'(rx_valid), 32'(vecs[v].exp_valid));
            check("vec_rx_data", 32'(rx_data), 32'(vecs[v].exp_data));
            tick();
            if (vecs[v].exp_valid) pulse_ready();
        end

        // Back-to-back frames into a full buffer.
        push(K_BYTE, 8'h11);
        send_frame(8'h11, 1'b1);
        push(K_OVR, 8'h00);
        send_frame(8'h22, 1'b1);
        wait_idle();
        repeat (3) tick();
        @(negedge clk);
        check("ovr_data_kept", 32'(rx_data), 32'h11);
        check("ovr_valid_kept", 32'(rx_valid), 32'd1);
        tick();

        // Ready coincides with the load edge: new byte replaces the old one.
        push(K_BYTE, 8'h22);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (155) tick();
                rx_ready = 1'b1;
                tick();
                rx_ready = 1'b0;
            end
        join
        @(negedge clk);
        check("swap_valid", 32'(rx_valid), 32'd1);
        check("swap_data", 32'(rx_data), 32'h22);
        tick();

        // Asynchronous reset in data bit 4 of 0xFF, buffer still holding 0x22.
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (CPB + 4 * CPB + CPB / 2) tick();
                check("pre_rst_busy", 32'(rx_busy), 32'd1);
                reset_n = 1'b0;
                #1;
                check("mid_rst_busy", 32'(rx_busy), 32'd0);
                check("mid_rst_valid", 32'(rx_valid), 32'd0);
                check("mid_rst_data", 32'(rx_data), 32'h00);
                check("mid_rst_ferr", 32'(frame_err), 32'd0);
                check("mid_rst_ovr", 32'(overrun), 32'd0);
            end
        join
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        push(K_BYTE, 8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_idle();
        repeat (2) tick();
        @(negedge clk);
        check("post_rst_valid", 32'(rx_valid), 32'd1);
        check("post_rst_data", 32'(rx_data), 32'h5A);
        tick();
        pulse_ready();

        repeat (20) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
